// File: rtl/dmem_access_ctrl.sv
// Load/store access controller for a word-wide, single-port data memory.
// Handles big-endian byte/half lanes, alignment checks and read-modify-write sub-word stores.
module dmem_access_ctrl #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Req,
  input  logic [2:0]               Op,
  input  logic [31:0]              Addr,
  input  logic [DATA_WIDTH-1:0]    StoreData,
  output logic                     Busy,
  output logic                     Done,
  output logic                     AlignErr,
  output logic [DATA_WIDTH-1:0]    LoadData,
  output logic [ADDRESS_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0]    MemWriteData,
  input  logic [DATA_WIDTH-1:0]    MemReadData,
  output logic                     MemWrite
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [15:0] sdata;
    logic        err;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;

  logic                  accept;
  logic                  misalign;
  logic                  is_store_q;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  // Bits above the word-index field are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:ADDRESS_WIDTH+2];

  assign accept     = (state == IDLE) && Req;
  assign is_store_q = (req_q.op == OP_SB) || (req_q.op == OP_SH);

  always_comb begin
    misalign = 1'b0;
    case (Op)
      OP_LH, OP_LHU, OP_SH: misalign = Addr[0];
      OP_LW, OP_SW:         misalign = (Addr[1:0] != 2'b00);
      default:              misalign = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Req) state_nxt = misalign ? DONE : ((Op == OP_SW) ? WRITE : READ);
      READ:    state_nxt = is_store_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from registered state so reset kills MemWrite without waiting for an edge.
  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);
  assign AlignErr = (state == DONE) && req_q.err;
  assign MemWrite = (state == WRITE);

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    rd_byte = MemReadData[31:24];
    case (req_q.off)
      2'd1:    rd_byte = MemReadData[23:16];
      2'd2:    rd_byte = MemReadData[15:8];
      2'd3:    rd_byte = MemReadData[7:0];
      default: rd_byte = MemReadData[31:24];
    endcase
    rd_half = req_q.off[1] ? MemReadData[15:0] : MemReadData[31:16];

    case (req_q.op)
      OP_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_ext = {24'd0, rd_byte};
      OP_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_ext = {16'd0, rd_half};
      default: load_ext = MemReadData;
    endcase

    merged = MemReadData;
    if (req_q.op == OP_SB) begin
      case (req_q.off)
        2'd0:    merged[31:24] = req_q.sdata[7:0];
        2'd1:    merged[23:16] = req_q.sdata[7:0];
        2'd2:    merged[15:8]  = req_q.sdata[7:0];
        default: merged[7:0]   = req_q.sdata[7:0];
      endcase
    end else if (req_q.off[1]) begin
      merged[15:0]  = req_q.sdata;
    end else begin
      merged[31:16] = req_q.sdata;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      req_q        <= '0;
      MemAddr      <= '0;
      MemWriteData <= '0;
      LoadData     <= '0;
    end else begin
      if (accept) begin
        req_q.op    <= Op;
        req_q.off   <= Addr[1:0];
        req_q.sdata <= StoreData[15:0];
        req_q.err   <= misalign;
        MemAddr     <= Addr[ADDRESS_WIDTH+1:2];
        if (!misalign && (Op == OP_SW)) MemWriteData <= StoreData;
      end
      if (state == READ) begin
        if (is_store_q) MemWriteData <= merged;
        else            LoadData     <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural word memory.
module tb_dmem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Req = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] StoreData = 32'd0;
  logic        Busy, Done, AlignErr, MemWrite;
  logic [31:0] LoadData, MemWriteData, MemReadData;
  logic [15:0] MemAddr;

  logic [31:0] mem [0:63];

  int nvec = 0;
  int nmis = 0;

  dmem_access_ctrl #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Op(Op), .Addr(Addr), .StoreData(StoreData),
    .Busy(Busy), .Done(Done), .AlignErr(AlignErr), .LoadData(LoadData),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemReadData(MemReadData),
    .MemWrite(MemWrite)
  );

  always #5 Clk = ~Clk;

  assign MemReadData = mem[MemAddr[5:0]];
  always @(posedge Clk) if (MemWrite) mem[MemAddr[5:0]] <= MemWriteData;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  // Issue one op from IDLE; report Done latency, MemWrite count/cycle, AlignErr, MemAddr in cycle N+1.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd,
                       output int lat, output int wr, output int wr_at,
                       output logic err, output logic [15:0] ma);
    Req = 1'b1; Op = op; Addr = a; StoreData = sd;
    cyc();
    Req = 1'b0;
    lat = 0; wr = 0; wr_at = 0; err = 1'b0; ma = MemAddr;
    for (int k = 1; k <= 8; k++) begin
      if (MemWrite) begin wr++; wr_at = k; end
      if (Done) begin lat = k; err = AlignErr; break; end
      cyc();
    end
    if (lat == 0) chk("done_timeout", 32'(lat), 32'hFFFF_FFFF);
    cyc();
  endtask

  int lat, wr, wr_at;
  logic err;
  logic [15:0] ma;
  logic [2:0] trace [0:5];
  int ndone;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset state
    #12;
    chk("rst_ctrl", {12'd0, Busy, Done, AlignErr, MemWrite, MemAddr}, 32'd0);
    chk("rst_mwd", MemWriteData, 32'd0);
    chk("rst_ld", LoadData, 32'd0);
    Rst_n = 1'b1;
    cyc();

    // SW then LW
    do_op(3'd7, 32'h10, 32'hDEADBEEF, lat, wr, wr_at, err, ma);
    chk("sw_maddr", {16'd0, ma}, 32'd4);
    chk("sw_lat", lat, 2);
    chk("sw_wr_cnt", wr, 1);
    chk("sw_wr_at", wr_at, 1);
    chk("sw_err", {31'd0, err}, 32'd0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    do_op(3'd2, 32'h10, 32'h0, lat, wr, wr_at, err, ma);
    chk("lw_lat", lat, 2);
    chk("lw_wr_cnt", wr, 0);
    chk("lw_data", LoadData, 32'hDEADBEEF);

    // Sub-word RMW stores
    do_op(3'd5, 32'h11, 32'hFFFFFF12, lat, wr, wr_at, err, ma);
    chk("sb_lat", lat, 3);
    chk("sb_wr_at", wr_at, 2);
    chk("sb_mem", mem[4], 32'hDE12BEEF);
    do_op(3'd6, 32'h12, 32'h1234CAFE, lat, wr, wr_at, err, ma);
    chk("sh_lat", lat, 3);
    chk("sh_mem", mem[4], 32'hDE12CAFE);
    chk("st_keeps_ld", LoadData, 32'hDEADBEEF);

    // Load extension
    mem[4] = 32'h80FF7F01;
    do_op(3'd0, 32'h10, 0, lat, wr, wr_at, err, ma); chk("lb_0", LoadData, 32'hFFFFFF80);
    do_op(3'd3, 32'h10, 0, lat, wr, wr_at, err, ma); chk("lbu_0", LoadData, 32'h00000080);
    do_op(3'd0, 32'h12, 0, lat, wr, wr_at, err, ma); chk("lb_2", LoadData, 32'h0000007F);
    do_op(3'd0, 32'h11, 0, lat, wr, wr_at, err, ma); chk("lb_1", LoadData, 32'hFFFFFFFF);
    do_op(3'd3, 32'h13, 0, lat, wr, wr_at, err, ma); chk("lbu_3", LoadData, 32'h00000001);
    do_op(3'd1, 32'h10, 0, lat, wr, wr_at, err, ma); chk("lh_0", LoadData, 32'hFFFF80FF);
    do_op(3'd4, 32'h12, 0, lat, wr, wr_at, err, ma); chk("lhu_2", LoadData, 32'h00007F01);
    do_op(3'd1, 32'h12, 0, lat, wr, wr_at, err, ma); chk("lh_2", LoadData, 32'h00007F01);
    do_op(3'd4, 32'h10, 0, lat, wr, wr_at, err, ma); chk("lhu_0", LoadData, 32'h000080FF);
    chk("ld_lat", lat, 2);

    // Misaligned accesses
    do_op(3'd2, 32'h12, 0, lat, wr, wr_at, err, ma);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_err", {31'd0, err}, 32'd1);
    chk("lw_mis_ld", LoadData, 32'h000080FF);
    do_op(3'd6, 32'h13, 32'hBEEF, lat, wr, wr_at, err, ma);
    chk("sh_mis_lat", lat, 1);
    chk("sh_mis_err", {31'd0, err}, 32'd1);
    chk("sh_mis_wr", wr, 0);
    chk("sh_mis_mem", mem[4], 32'h80FF7F01);
    do_op(3'd7, 32'h16, 32'h0, lat, wr, wr_at, err, ma);
    chk("sw_mis_err", {31'd0, err}, 32'd1);
    chk("sw_mis_mem", mem[5], 32'h0);
    do_op(3'd3, 32'h13, 0, lat, wr, wr_at, err, ma);
    chk("ok_after_err", {31'd0, err}, 32'd0);

    // Req held high across back-to-back LW / SW
    trace[0] = 3'b100; trace[1] = 3'b110; trace[2] = 3'b000;
    trace[3] = 3'b101; trace[4] = 3'b110; trace[5] = 3'b000;
    ndone = 0;
    Req = 1'b1; Op = 3'd2; Addr = 32'h10; StoreData = 32'h0;
    cyc();
    Op = 3'd7; Addr = 32'h14; StoreData = 32'h5A5A1234;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("b2b_c%0d", k + 1), {29'd0, Busy, Done, MemWrite}, {29'd0, trace[k]});
      if (Done) ndone++;
      if (k == 3) Req = 1'b0;
      cyc();
    end
    chk("b2b_ndone", ndone, 2);
    chk("b2b_ld", LoadData, 32'h80FF7F01);
    chk("b2b_mem", mem[5], 32'h5A5A1234);

    // Reset during the WRITE cycle of an SB
    mem[4] = 32'h11223344;
    Req = 1'b1; Op = 3'd5; Addr = 32'h10; StoreData = 32'hAA;
    cyc();
    Req = 1'b0;
    cyc();
    chk("rmw_wr_on", {31'd0, MemWrite}, 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_mw_async", {31'd0, MemWrite}, 32'd0);
    chk("rst2_ctrl", {12'd0, Busy, Done, AlignErr, MemWrite, MemAddr}, 32'd0);
    chk("rst2_mwd", MemWriteData, 32'd0);
    chk("rst2_ld", LoadData, 32'd0);
    cyc();
    chk("rst2_mem", mem[4], 32'h11223344);
    Rst_n = 1'b1;
    cyc();
    do_op(3'd2, 32'h10, 0, lat, wr, wr_at, err, ma);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_ld", LoadData, 32'h11223344);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
